// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   Instruction-fetch stage that sits directly after the PC register. Each
//   cycle it issues one instruction-memory read at the current PC. The read
//   data arrives one cycle later and is stored, together with its PC, in a
//   small FIFO. The FIFO head goes to decode through a valid/ready handshake.
//   stall_req holds the PC register whenever there is not enough room for
//   another fetch. A branch flush throws away every buffered and in-flight
//   fetch.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | core held by chip_enable = 0; no fetch, FIFO and request cleared
//   RUN   | fetching one instruction per cycle, subject to stall/flush
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   pc, chip_enable, flush        inputs from the PC register / branch unit
//   imem_en, imem_addr            instruction memory read request
//   imem_rdata                    read data, one cycle after imem_en
//   stall_req                     hold the PC register
//   if_valid, if_pc, if_inst      FIFO head presented to decode
//   id_ready                      decode accepts the head this cycle

module if_fetch_buffer #(
  parameter int DEPTH  = 2,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              chip_enable,
  input  logic              flush,
  output logic              imem_en,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              stall_req,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = CNT_W + 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic                req_v_q, req_v_d;
  logic [31:0]         req_pc_q, req_pc_d;
  logic [31:0]         pc_mem_q   [DEPTH];
  logic [31:0]         pc_mem_d   [DEPTH];
  logic [INST_W-1:0]   inst_mem_q [DEPTH];
  logic [INST_W-1:0]   inst_mem_d [DEPTH];

  logic                run;
  logic                pop;
  logic                push;
  logic [OCC_W-1:0]    occ_after;
  logic [OCC_W-1:0]    occ_limit;

  assign run      = (state_q == S_RUN);
  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign if_inst  = if_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign pop      = if_valid & id_ready;
  assign push     = run & chip_enable & req_v_q & ~flush;

  // Occupancy once the outstanding request lands, compared without wrap:
  // count + req_v >= DEPTH + pop  is  count + req_v - pop >= DEPTH.
  assign occ_after = OCC_W'(count_q) + OCC_W'(req_v_q);
  assign occ_limit = OCC_W'(DEPTH) + OCC_W'(pop);
  assign stall_req = ~flush & run & (occ_after >= occ_limit);

  assign imem_en   = run & chip_enable & ~flush & ~stall_req;
  assign imem_addr = pc;

  always_comb begin
    state_d    = chip_enable ? S_RUN : S_IDLE;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    req_v_d    = imem_en;
    req_pc_d   = imem_en ? pc : req_pc_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    if (!run || !chip_enable || flush) begin
      // Data returning after a flush or while the core is held is dropped.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      req_v_d  = 1'b0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = req_pc_q;
        inst_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      req_v_q    <= req_v_d;
      req_pc_q   <= req_pc_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        chip_enable;
  logic        flush;
  logic [31:0] branch_addr;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_req;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  int n_vec  = 0;
  int n_miss = 0;

  if_fetch_buffer #(.DEPTH(2), .INST_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .chip_enable(chip_enable),
    .flush      (flush),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .stall_req  (stall_req),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .id_ready   (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h2008_0005 + (a << 6);
  endfunction

  // PC register: hold while idle-reset, load branch on flush, advance on issue.
  always @(posedge clk or posedge rst) begin
    if (rst)               pc <= 32'h0;
    else if (!chip_enable) pc <= 32'h0;
    else if (flush)        pc <= branch_addr;
    else if (imem_en)      pc <= pc + 32'd4;
  end

  // Instruction memory, one-cycle read latency; junk when not enabled.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? inst_of(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"},    if_pc, exp_pc);
    chk({tag, "_inst"},  if_inst, inst_of(exp_pc));
  endtask

  initial begin
    rst = 1'b1; chip_enable = 1'b0; flush = 1'b0; id_ready = 1'b0;
    branch_addr = 32'h0;
    repeat (2) cyc();
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);

    // Streaming: A idle, B issue 0, C issue 4, D head 0 ...
    cyc(); rst = 1'b0; chip_enable = 1'b1; id_ready = 1'b1; #1;       // A
    chk("a_imem_en", 32'(imem_en), 32'd0);
    cyc(); #1;                                                          // B
    chk("b_imem_en", 32'(imem_en), 32'd1);
    chk("b_addr", imem_addr, 32'h0);
    cyc(); #1;                                                          // C
    chk("c_addr", imem_addr, 32'h4);
    chk("c_valid", 32'(if_valid), 32'd0);
    cyc(); #1; chk_head("d_head", 32'h0);                              // D
    chk("d_inst_lit", if_inst, 32'h2008_0005);
    cyc(); #1; chk_head("e_head", 32'h4);                              // E
    cyc(); #1; chk_head("f_head", 32'h8);                              // F
    cyc(); #1; chk_head("g_head", 32'hC);                              // G

    // Back-pressure for 6 cycles (H..M).
    cyc(); id_ready = 1'b0; #1;                                         // H
    chk_head("h_head", 32'h10);
    chk("h_stall", 32'(stall_req), 32'd1);
    chk("h_imem_en", 32'(imem_en), 32'd0);
    for (int i = 0; i < 5; i++) begin                                   // I..M
      cyc(); #1;
      chk_head("hold_head", 32'h10);
      chk("hold_stall", 32'(stall_req), 32'd1);
      chk("hold_imem_en", 32'(imem_en), 32'd0);
    end
    cyc(); id_ready = 1'b1; #1;                                         // N
    chk_head("n_head", 32'h10);
    chk("n_stall", 32'(stall_req), 32'd0);
    chk("n_addr", imem_addr, 32'h18);
    chk("n_imem_en", 32'(imem_en), 32'd1);
    cyc(); #1; chk_head("o_head", 32'h14);                             // O
    cyc(); #1; chk_head("p_head", 32'h18);                             // P
    cyc(); #1; chk_head("q_head", 32'h1C);                             // Q

    // chip_enable low for 3 cycles (R..T).
    cyc(); chip_enable = 1'b0; #1;                                      // R
    chk("r_imem_en", 32'(imem_en), 32'd0);
    cyc(); #1;                                                          // S
    chk("s_valid", 32'(if_valid), 32'd0);
    chk("s_imem_en", 32'(imem_en), 32'd0);
    cyc(); #1;                                                          // T
    chk("t_valid", 32'(if_valid), 32'd0);
    cyc(); chip_enable = 1'b1; #1;                                      // U
    chk("u_imem_en", 32'(imem_en), 32'd0);
    cyc(); #1;                                                          // V
    chk("v_imem_en", 32'(imem_en), 32'd1);
    chk("v_addr", imem_addr, 32'h0);
    cyc(); #1;                                                          // W
    chk("w_addr", imem_addr, 32'h4);
    cyc(); #1; chk_head("x_head", 32'h0);                              // X

    // Flush with pc=4 at head and pc=8 in flight.
    cyc(); flush = 1'b1; branch_addr = 32'h40; #1;                      // Y
    chk_head("y_head", 32'h4);
    chk("y_imem_en", 32'(imem_en), 32'd0);
    chk("y_stall", 32'(stall_req), 32'd0);
    cyc(); flush = 1'b0; #1;                                            // Z
    chk("z_valid", 32'(if_valid), 32'd0);
    chk("z_imem_en", 32'(imem_en), 32'd1);
    chk("z_addr", imem_addr, 32'h40);
    cyc(); #1;                                                          // AA
    chk("aa_valid", 32'(if_valid), 32'd0);
    cyc(); id_ready = 1'b0; #1;                                         // AB
    chk_head("ab_head", 32'h40);
    chk("ab_stall", 32'(stall_req), 32'd1);
    cyc(); #1;                                                          // AC
    chk_head("ac_head", 32'h40);
    chk("ac_stall", 32'(stall_req), 32'd1);
    chk("ac_imem_en", 32'(imem_en), 32'd0);

    // Flush while full and decode stalled.
    cyc(); flush = 1'b1; branch_addr = 32'h80; #1;                      // AD
    chk("ad_stall", 32'(stall_req), 32'd0);
    chk("ad_imem_en", 32'(imem_en), 32'd0);
    cyc(); flush = 1'b0; #1;                                            // AE
    chk("ae_valid", 32'(if_valid), 32'd0);
    chk("ae_addr", imem_addr, 32'h80);
    chk("ae_imem_en", 32'(imem_en), 32'd1);
    cyc(); #1;                                                          // AF
    chk("af_addr", imem_addr, 32'h84);
    chk("af_imem_en", 32'(imem_en), 32'd1);
    cyc(); #1;                                                          // AG
    chk("ag_stall", 32'(stall_req), 32'd1);
    cyc(); #1;                                                          // AH
    chk_head("ah_head", 32'h80);
    chk("ah_stall", 32'(stall_req), 32'd1);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #1; rst = 1'b1; #1;
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd0);
    chk("arst_imem_en", 32'(imem_en), 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    #1; rst = 1'b0;
    cyc(); #1;
    chk("post_valid", 32'(if_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
